// File: rtl/gbt_link_supervisor.sv
// gbt_link_supervisor
// Per-link bring-up and health supervisor for a bank of GBT links. Each link
// gets its own reset/lock/stability FSM with retry limiting, a permanent
// FAILED latch and a saturating counter of involuntary drops.
module gbt_link_supervisor #(
    parameter int NUM_LINKS           = 4,
    parameter int RESET_PULSE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 12_000_000,
    parameter int STABLE_CYCLES       = 1200,
    parameter int MAX_RETRIES         = 7,
    parameter int CNT_W               = 16,
    localparam int RETRY_W            = $clog2(MAX_RETRIES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LINKS-1:0]         los_i,
    input  logic [NUM_LINKS-1:0]         tx_ready_i,
    input  logic [NUM_LINKS-1:0]         rx_ready_i,
    input  logic [NUM_LINKS-1:0]         link_ready_i,
    input  logic [NUM_LINKS-1:0]         manual_reset_i,
    input  logic                         clear_counters_i,
    output logic [NUM_LINKS-1:0]         gbt_reset_o,
    output logic [NUM_LINKS-1:0]         link_up_o,
    output logic [NUM_LINKS-1:0]         link_failed_o,
    output logic [NUM_LINKS*RETRY_W-1:0] retry_count_o,
    output logic [NUM_LINKS*CNT_W-1:0]   drop_count_o
);

    // One shared timer per link serves the reset pulse, the lock timeout and
    // the stability window, so it is sized for the longest of the three.
    localparam int TMAX_A  = (RESET_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RESET_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int TMAX    = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    localparam logic [TIMER_W-1:0] RESET_LAST  = TIMER_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    localparam int SYNC_W = 4 * NUM_LINKS;

    typedef enum logic [2:0] {
        ST_LOS       = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_UP        = 3'd4,
        ST_FAILED    = 3'd5
    } state_t;

    // Synchroniser layout: {los, tx_ready, rx_ready, link_ready}
    logic [SYNC_W-1:0]    sync1_d, sync1_q;
    logic [SYNC_W-1:0]    sync2_d, sync2_q;
    logic [NUM_LINKS-1:0] los_s;
    logic [NUM_LINKS-1:0] ready_s;

    // Next value of the two synchroniser stages
    always_comb begin
        sync1_d = {los_i, tx_ready_i, rx_ready_i, link_ready_i};
        sync2_d = sync1_q;
    end

    // Two-flop synchroniser for every asynchronous status bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign los_s   = sync2_q[3*NUM_LINKS +: NUM_LINKS];
    assign ready_s = sync2_q[2*NUM_LINKS +: NUM_LINKS]
                   & sync2_q[1*NUM_LINKS +: NUM_LINKS]
                   & sync2_q[0*NUM_LINKS +: NUM_LINKS];

    for (genvar g = 0; g < NUM_LINKS; g++) begin : g_link
        state_t             state_q, state_d;
        logic [TIMER_W-1:0] timer_q, timer_d;
        logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
        logic [CNT_W-1:0]   drop_q, drop_d;
        logic               drop_evt;
        logic               restart;

        // Link FSM: LOS beats manual restart, manual restart beats normal flow
        always_comb begin
            state_d   = state_q;
            retry_d   = retry_q;
            drop_evt  = 1'b0;
            restart   = 1'b0;
            retry_inc = retry_q + RETRY_W'(1);

            if (los_s[g]) begin
                state_d  = ST_LOS;
                retry_d  = '0;
                drop_evt = (state_q == ST_UP);
            end else if (manual_reset_i[g] && (state_q != ST_LOS)) begin
                // Restart even when already in RESET so the pulse is full length
                state_d = ST_RESET;
                retry_d = '0;
                restart = 1'b1;
            end else begin
                case (state_q)
                    ST_LOS: begin
                        state_d = ST_RESET;
                    end
                    ST_RESET: begin
                        if (timer_q == RESET_LAST) begin
                            state_d = ST_WAIT_LOCK;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (ready_s[g]) begin
                            state_d = ST_STABLE;
                        end else if (timer_q == LOCK_LAST) begin
                            retry_d = retry_inc;
                            state_d = (retry_inc == RETRY_MAX) ? ST_FAILED : ST_RESET;
                        end
                    end
                    ST_STABLE: begin
                        if (!ready_s[g]) begin
                            retry_d = retry_inc;
                            state_d = (retry_inc == RETRY_MAX) ? ST_FAILED : ST_RESET;
                        end else if (timer_q == STABLE_LAST) begin
                            state_d = ST_UP;
                            retry_d = '0;
                        end
                    end
                    ST_UP: begin
                        if (!ready_s[g]) begin
                            state_d  = ST_RESET;
                            drop_evt = 1'b1;
                        end
                    end
                    ST_FAILED: begin
                        state_d = ST_FAILED;
                    end
                    default: begin
                        state_d = ST_RESET;
                        retry_d = '0;
                    end
                endcase
            end

            // Timer restarts from zero on every state entry and idles at zero
            // in the untimed states
            if (restart || (state_d != state_q)) begin
                timer_d = '0;
            end else if (state_q inside {ST_RESET, ST_WAIT_LOCK, ST_STABLE}) begin
                timer_d = timer_q + TIMER_W'(1);
            end else begin
                timer_d = '0;
            end
        end

        // Saturating drop counter; a clear overrides a simultaneous drop
        always_comb begin
            if (clear_counters_i) begin
                drop_d = '0;
            end else if (drop_evt && (drop_q != '1)) begin
                drop_d = drop_q + CNT_W'(1);
            end else begin
                drop_d = drop_q;
            end
        end

        // Per-link state, timer, retry and drop registers
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_RESET;
                timer_q <= '0;
                retry_q <= '0;
                drop_q  <= '0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                retry_q <= retry_d;
                drop_q  <= drop_d;
            end
        end

        assign gbt_reset_o[g]   = (state_q == ST_LOS) || (state_q == ST_RESET) ||
                                  (state_q == ST_FAILED);
        assign link_up_o[g]     = (state_q == ST_UP);
        assign link_failed_o[g] = (state_q == ST_FAILED);
        assign retry_count_o[g*RETRY_W +: RETRY_W] = retry_q;
        assign drop_count_o[g*CNT_W +: CNT_W]      = drop_q;
    end

endmodule

// File: doc/gbt_link_supervisor.md
# gbt_link_supervisor

Per-link bring-up and health supervisor for a bank of GBT links. It sits between the board-level SFP status/GBT bank ready flags and the `gbtbank_general_reset_i` input of each GBT link instance. It sequences reset pulses, waits for lock with a timeout and requires a stability window before declaring a link up. It retries failed lock attempts, latches permanent failure, and keeps saturating drop counters for readout.

## Interface
Parameters:
- NUM_LINKS, 4, number of supervised links (1..8)
- RESET_PULSE_CYCLES, 16, length of each gbt_reset_o pulse
- LOCK_TIMEOUT_CYCLES, 12_000_000, maximum wait for all ready flags (100 ms at 120 MHz)
- STABLE_CYCLES, 1200, cycles the ready flags must stay high before link_up_o asserts
- MAX_RETRIES, 7, failed attempts tolerated before FAILED
- CNT_W, 16, width of each drop counter

Ports:
- clk  in  1  120 MHz DRP/system clock; single clock domain
- reset  in  1  synchronous, active-high
- los_i  in  NUM_LINKS  SFP loss-of-signal, async
- tx_ready_i  in  NUM_LINKS  GBT TX ready, async
- rx_ready_i  in  NUM_LINKS  GBT RX ready, async
- link_ready_i  in  NUM_LINKS  GBT link ready, async
- manual_reset_i  in  NUM_LINKS  one-cycle request to restart the link, synchronous to clk
- clear_counters_i  in  1  one-cycle clear of all drop counters
- gbt_reset_o  out  NUM_LINKS  drives gbtbank_general_reset_i
- link_up_o  out  NUM_LINKS  link in UP state
- link_failed_o  out  NUM_LINKS  link in FAILED state
- retry_count_o  out  NUM_LINKS*$clog2(MAX_RETRIES+1)  current retry count, link i at slice i
- drop_count_o  out  NUM_LINKS*CNT_W  saturating involuntary-drop counters, link i at slice i

## Operation
- Async inputs pass through a 2-flop synchroniser per bit. Derived signals: los_s, and ready_s = tx_ready & rx_ready & link_ready, both synchronised.
- Each link runs an independent FSM with states LOS, RESET, WAIT_LOCK, STABLE, UP and FAILED.
- Any state, los_s=1 -> LOS. This has highest priority. retry cleared. gbt_reset_o=1.
- LOS: when los_s=0 -> RESET.
- Any state except LOS, manual_reset_i=1 -> RESET. retry cleared. Not counted as a drop.
- RESET: gbt_reset_o=1 for exactly RESET_PULSE_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK: gbt_reset_o=0.
  - ready_s=1 -> STABLE.
  - Timer reaches LOCK_TIMEOUT_CYCLES without ready -> fail attempt.
- STABLE: counter runs while ready_s=1.
  - Count reaches STABLE_CYCLES -> UP, retry cleared.
  - ready_s=0 -> fail attempt.
- Fail attempt: retry+1.
  - If the new retry equals MAX_RETRIES -> FAILED.
  - Otherwise -> RESET.
- UP: link_up_o=1.
  - ready_s=0 -> drop counter +1, then RESET. retry unchanged (0).
  - los_s=1 -> drop counter +1, then LOS.
- FAILED: gbt_reset_o=1, link_failed_o=1. Exit only via manual_reset_i or los_s.
- Drop counters saturate at 2^CNT_W-1. clear_counters_i zeroes all of them. A clear coincident with a drop yields 0 (clear wins).
- Reset values:
  - all FSMs in RESET with timer 0
  - gbt_reset_o all ones
  - link_up_o = 0, link_failed_o = 0
  - retry_count_o = 0, drop_count_o = 0
  - synchronisers cleared

## Timing
- Synchroniser latency is 2 clk. All outputs are registered Moore outputs of the state and counter registers.
- After reset deasserts, gbt_reset_o stays high for RESET_PULSE_CYCLES cycles.
- With raw ready inputs high from cycle t and the link in WAIT_LOCK, link_up_o rises at cycle t+3+STABLE_CYCLES.
- manual_reset_i at cycle t: gbt_reset_o=1 and link_up_o=0 from t+1.
- los_i rising at cycle t: gbt_reset_o=1 and link_up_o=0 from t+3.
- The WAIT_LOCK timer and STABLE counter restart at 0 on every entry.
- Links never interact except through the shared clear_counters_i.
- reset asserted mid-operation returns every link to the reset state in the next cycle, regardless of FSM state.

## Test plan
Bench parameters: NUM_LINKS=2, RESET_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=3, CNT_W=4.

1. **Nominal bring-up:** release reset, raise all ready flags of link 0 at cycle 10 -> gbt_reset_o[0] high for cycles 0-3, link_up_o[0] rises at cycle 21, retry_count 0.
2. **Lock timeout:** keep ready low -> three reset/timeout rounds, then link_failed_o=1 and retry_count=3, with gbt_reset_o held high. manual_reset_i -> RESET, retry_count 0.
3. **Stability glitch:** drop rx_ready for 1 cycle at STABLE count 5 -> retry_count 1, new RESET pulse, no link_up_o.
4. **Drop counting and saturation:** cause 17 drops from UP -> drop_count saturates at 15. clear_counters_i together with an 18th drop -> 0.
5. **LOS priority:** assert los_i[1] while UP and manual_reset_i[1] is pulsed -> state LOS, drop_count[1]+1, link_up_o[1] low at +3, link 0 unaffected. Release LOS -> RESET pulse of 4 cycles.
6. **Reset mid-operation:** assert reset while link 0 is in STABLE and link 1 is in FAILED -> both at reset values one cycle later.
